// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment symbol sequencer: glyph table and rate helper.
package seg7_pkg;

  localparam int unsigned GLYPH_N = 16;
  localparam int unsigned SEG_W   = 7;

  // Segment patterns {g,f,e,d,c,b,a} for letters A..P.
  localparam logic [SEG_W-1:0] GLYPH [GLYPH_N] = '{
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76,
    7'h06, 7'h1E, 7'h75, 7'h38, 7'h37, 7'h54, 7'h3F, 7'h73
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Step period in clock cycles for a given rate select.
  function automatic logic [31:0] rate_period(input logic [31:0] tick_div,
                                              input logic [1:0]  rate);
    return tick_div >> rate;
  endfunction

endpackage

// File: rtl/seg7_debounce.sv
// Level debouncer: output follows the synchronised input once it has differed
// for DEB_CYCLES consecutive cycles; rise flags the cycle the level goes high.
module seg7_debounce #(
  parameter int unsigned DEB_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_sync,
  output logic dout,
  output logic rise
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             flip_c;

  // Count consecutive disagreeing samples; flip the level on the last one.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    flip_c = (din_sync != dout_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
    if (din_sync != dout_q) begin
      if (flip_c) begin
        dout_d = din_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debouncer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
  // Same-cycle pulse so the step lands on the edge the level is accepted.
  assign rise = flip_c & din_sync;

endmodule

// File: rtl/seg7_symbol_sequencer.sv
// Steps an index through a glyph table on prescaler ticks or debounced button
// presses, and drives one 7-segment digit plus a pause indicator.
module seg7_symbol_sequencer
  import seg7_pkg::*;
#(
  parameter int unsigned  TICK_DIV    = 25_000_000,
  parameter int unsigned  SYMBOLS     = 16,
  parameter int unsigned  DEB_CYCLES  = 250_000,
  parameter bit           SEG_ACT_LOW = 1'b0,
  localparam int unsigned IDX_W       = $clog2(SYMBOLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       rate,
  input  logic             step_btn,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [IDX_W-1:0] idx,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic             wrap
);

  localparam int unsigned      CNT_W    = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYMBOLS - 1);
  localparam logic [SEG_W-1:0] SEG_MASK = {SEG_W{SEG_ACT_LOW}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      per_m1_c;
  logic             tick_c;
  logic             btn_meta_q, btn_sync_q;
  logic             deb_level, deb_rise;
  logic             step_c, adv_c;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       glyph_sel_c;

  // Prescaler: compare against the current rate's period, restart on tick.
  always_comb begin
    per_m1_c = rate_period(32'(TICK_DIV), rate) - 32'd1;
    tick_c   = (32'(cnt_q) >= per_m1_c);
    cnt_d    = cnt_q + CNT_W'(1);
    if (!en || load || tick_c) begin
      cnt_d = '0;
    end
  end

  // Two-flop synchroniser for the raw push button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      btn_meta_q <= step_btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  seg7_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_sync (btn_sync_q),
    .dout     (deb_level),
    .rise     (deb_rise)
  );

  // A press only counts while the accepted level is still low.
  assign step_c = deb_rise & ~deb_level;
  assign adv_c  = (en & tick_c) | step_c;

  // Index next state: load wins, otherwise a single advance with wrap.
  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = ({1'b0, load_idx} > (IDX_W + 1)'(SYMBOLS - 1)) ? IDX_LAST : load_idx;
    end else if (adv_c) begin
      if (!dir) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
      end
    end
  end

  // Registered outputs: wrap with the index update, glyph and dp one cycle behind.
  always_comb begin
    wrap_d      = 1'b0;
    seg_d       = SEG_BLANK;
    dp_d        = 1'b0;
    glyph_sel_c = 4'(idx_q);
    if (!load && adv_c) begin
      wrap_d = dir ? (idx_q == '0) : (idx_q == IDX_LAST);
    end
    seg_d = GLYPH[glyph_sel_c] ^ SEG_MASK;
    dp_d  = ~en ^ SEG_ACT_LOW;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      seg_q  <= GLYPH[0] ^ SEG_MASK;
      dp_q   <= 1'b1 ^ SEG_ACT_LOW;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign idx  = idx_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seg7_symbol_sequencer.sv
// Directed bench for seg7_symbol_sequencer. Index changes on the main instance
// are predicted (value, wrap, cycle) into a queue and matched by a monitor.
module tb_seg7_symbol_sequencer;

  localparam logic [6:0] GLYPH_REF [16] = '{
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76,
    7'h06, 7'h1E, 7'h75, 7'h38, 7'h37, 7'h54, 7'h3F, 7'h73
  };

  typedef struct {
    logic [3:0]  idx;
    logic        wrap;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Main instance: 16 symbols, active-high segments.
  logic       en, dir, step_btn, load;
  logic [1:0] rate;
  logic [3:0] load_idx;
  logic [3:0] idx;
  logic [6:0] seg;
  logic       dp, wrap;

  // Second instance: 10 symbols, active-low segments (clamp and polarity).
  logic       en2, dir2, step_btn2, load2;
  logic [1:0] rate2;
  logic [3:0] load_idx2;
  logic [3:0] idx2;
  logic [6:0] seg2;
  logic       dp2, wrap2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  exp_t        q[$];
  logic [3:0]  prev_idx = 4'd0;

  seg7_symbol_sequencer #(
    .TICK_DIV(16), .SYMBOLS(16), .DEB_CYCLES(4), .SEG_ACT_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .rate(rate),
    .step_btn(step_btn), .load(load), .load_idx(load_idx),
    .idx(idx), .seg(seg), .dp(dp), .wrap(wrap)
  );

  seg7_symbol_sequencer #(
    .TICK_DIV(16), .SYMBOLS(10), .DEB_CYCLES(4), .SEG_ACT_LOW(1'b1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .dir(dir2), .rate(rate2),
    .step_btn(step_btn2), .load(load2), .load_idx(load_idx2),
    .idx(idx2), .seg(seg2), .dp(dp2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: seg lags idx by one cycle; every idx change must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_idx = idx;
    end else begin
      check("seg_lag", 32'(seg), 32'(GLYPH_REF[prev_idx]));
      if (idx !== prev_idx) begin
        if (q.size() == 0) begin
          check("unexpected_adv", 32'(idx), 32'(prev_idx));
        end else begin
          e = q.pop_front();
          check("idx", 32'(idx), 32'(e.idx));
          check("wrap", 32'(wrap), 32'(e.wrap));
          check("adv_cycle", cyc, e.cyc);
        end
      end else begin
        check("no_wrap", 32'(wrap), 32'd0);
      end
      prev_idx = idx;
    end
  end

  initial begin
    int unsigned base;
    en = 0; dir = 0; rate = 2'd0; step_btn = 0; load = 0; load_idx = 4'd0;
    en2 = 0; dir2 = 0; rate2 = 2'd0; step_btn2 = 0; load2 = 0; load_idx2 = 4'd0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_seg", 32'(seg), 32'h77);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_seg_al", 32'(seg2), 32'h08);
    check("rst_dp_al", 32'(dp2), 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Up-count every 16 cycles through a full lap, one wrap at 15->0.
    base = cyc;
    en = 1;
    for (int i = 1; i <= 16; i++) begin
      q.push_back('{idx: 4'(i % 16), wrap: (i == 16), cyc: base + 16 * i});
    end
    @(negedge clk);
    check("dp_running", 32'(dp), 32'd0);
    repeat (255) @(negedge clk);

    // Down at idx 0 with rate 2: wrap to 15 after 4 cycles, then 14, 13.
    dir = 1; rate = 2'd2;
    base = cyc;
    q.push_back('{idx: 4'd15, wrap: 1'b1, cyc: base + 4});
    q.push_back('{idx: 4'd14, wrap: 1'b0, cyc: base + 8});
    q.push_back('{idx: 4'd13, wrap: 1'b0, cyc: base + 12});
    repeat (12) @(negedge clk);
    en = 0;
    repeat (2) @(negedge clk);
    check("dp_paused", 32'(dp), 32'd1);

    // Paused, bouncing press then hold: one down-step 6 cycles after stable.
    step_btn = 1;
    @(negedge clk);
    step_btn = 0;
    @(negedge clk);
    base = cyc;
    step_btn = 1;
    q.push_back('{idx: 4'd12, wrap: 1'b0, cyc: base + 6});
    repeat (20) @(negedge clk);
    step_btn = 0;
    repeat (20) @(negedge clk);
    check("press_once_idx", 32'(idx), 32'd12);

    // Load coincident with a tick: tick dropped, next tick a full period later.
    dir = 0; rate = 2'd0; en = 1;
    base = cyc;
    repeat (15) @(negedge clk);
    load = 1; load_idx = 4'd15;
    q.push_back('{idx: 4'd15, wrap: 1'b0, cyc: base + 16});
    q.push_back('{idx: 4'd0,  wrap: 1'b1, cyc: base + 32});
    q.push_back('{idx: 4'd1,  wrap: 1'b0, cyc: base + 48});
    @(negedge clk);
    load = 0;
    repeat (36) @(negedge clk);

    // Asynchronous reset mid-count, checked before any clock edge.
    #3;
    rst_n = 0;
    en = 0;
    #1;
    check("async_rst_idx", 32'(idx), 32'd0);
    check("async_rst_seg", 32'(seg), 32'h77);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    check("async_rst_dp", 32'(dp), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // 10-symbol instance: out-of-range load clamps to 9 without wrap.
    load2 = 1; load_idx2 = 4'd12;
    @(negedge clk);
    check("clamp_idx", 32'(idx2), 32'd9);
    check("clamp_wrap", 32'(wrap2), 32'd0);
    load2 = 0;
    @(negedge clk);
    check("clamp_seg_al", 32'(seg2), 32'h61);
    en2 = 1; dir2 = 0; rate2 = 2'd3;
    @(negedge clk);
    check("al_hold", 32'(idx2), 32'd9);
    @(negedge clk);
    check("al_up_wrap_idx", 32'(idx2), 32'd0);
    check("al_up_wrap", 32'(wrap2), 32'd1);
    dir2 = 1;
    @(negedge clk);
    check("al_wrap_pulse", 32'(wrap2), 32'd0);
    check("al_dp_running", 32'(dp2), 32'd1);
    @(negedge clk);
    check("al_dn_wrap_idx", 32'(idx2), 32'd9);
    check("al_dn_wrap", 32'(wrap2), 32'd1);
    load2 = 1; load_idx2 = 4'd3;
    @(negedge clk);
    check("al_load3", 32'(idx2), 32'd3);
    load2 = 0;
    @(negedge clk);
    check("al_seg3", 32'(seg2), 32'h21);
    en2 = 0;
    @(negedge clk);
    check("al_dp_paused", 32'(dp2), 32'd0);
    check("al_idx_held", 32'(idx2), 32'd3);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
